// File: rtl/chk_pkg.sv
// -----------------------------------------------------------------------------
// chk_pkg
// Shared types for the store checker: the checker FSM state encoding and the
// failure cause reported on fail_code.
// -----------------------------------------------------------------------------
package chk_pkg;

   // Checker FSM states. PASS/FAIL/TIMEOUT hold the verdict until reset or start.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_PASS    = 3'd2,
      S_FAIL    = 3'd3,
      S_TIMEOUT = 3'd4
   } chk_state_e;

   // Failure cause reported alongside the verdict.
   typedef enum logic [2:0] {
      F_NONE    = 3'd0,
      F_DATA    = 3'd1,
      F_ADDR    = 3'd2,
      F_ORDER   = 3'd3,
      F_DUP     = 3'd4,
      F_TIMEOUT = 3'd5
   } fail_e;

endpackage

// File: rtl/store_ref_table.sv
// -----------------------------------------------------------------------------
// store_ref_table
// Table of expected stores (address/data pairs) plus a per-entry comparator
// against the store currently on the core's bus. Only entries below num_act
// take part in a compare; the rest read back as no-hit.
//
// Ports
//   clk, reset         clock, asynchronous active-low reset (clears the table)
//   we, idx            write strobe / entry index (indices out of range ignored)
//   wr_addr, wr_data   entry contents to write
//   num_act            number of active entries
//   st_addr, st_data   store currently presented by the core
//   addr_hit           per active entry: address equal
//   full_hit           per active entry: address and data equal
// -----------------------------------------------------------------------------
module store_ref_table #(
   parameter int  NUM_CHECKS = 4,
   parameter int  ADDR_W     = 32,
   parameter int  DATA_W     = 32,
   localparam int IDX_W      = $clog2(NUM_CHECKS),
   localparam int CNT_W      = $clog2(NUM_CHECKS + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [IDX_W-1:0]      idx,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [CNT_W-1:0]      num_act,
   input  logic [ADDR_W-1:0]     st_addr,
   input  logic [DATA_W-1:0]     st_data,
   output logic [NUM_CHECKS-1:0] addr_hit,
   output logic [NUM_CHECKS-1:0] full_hit
);

   logic [ADDR_W-1:0] ent_addr_r [NUM_CHECKS];
   logic [DATA_W-1:0] ent_data_r [NUM_CHECKS];
   logic              idx_ok_s;

   // When the table depth is a power of two every encodable index is valid.
   if ((1 << IDX_W) == NUM_CHECKS) begin : g_idx_all
      assign idx_ok_s = 1'b1;
   end else begin : g_idx_range
      assign idx_ok_s = (idx < IDX_W'(NUM_CHECKS));
   end

   // Entry storage: cleared on reset, written one entry at a time.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CHECKS; i++) begin
            ent_addr_r[i] <= '0;
            ent_data_r[i] <= '0;
         end
      end else if (we && idx_ok_s) begin
         ent_addr_r[idx] <= wr_addr;
         ent_data_r[idx] <= wr_data;
      end
   end

   // Per-entry compare, masked to the active entries.
   always_comb begin
      addr_hit = '0;
      full_hit = '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
         if (CNT_W'(i) < num_act) begin
            addr_hit[i] = (st_addr == ent_addr_r[i]);
            full_hit[i] = (st_addr == ent_addr_r[i]) && (st_data == ent_data_r[i]);
         end else begin
            addr_hit[i] = 1'b0;
            full_hit[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/store_checker.sv
// -----------------------------------------------------------------------------
// store_checker
// Pass/fail monitor for data-memory stores of the pipelined core. A programmed
// table of expected stores is matched (in order or in any order), stores into
// an ignore window are skipped, anything else fails. A cycle budget bounds the
// run. The verdict, cause and offending store are held in registers.
//
// Ports
//   clk, reset                       core clock, asynchronous active-low reset
//   cfg_we/cfg_idx/cfg_addr/cfg_data table write (honoured in IDLE only)
//   num_checks                       active entries, sampled on start
//   ign_base/ign_mask                ignore window: (addr & mask) == (base & mask)
//   start                            arm the checker
//   MemWrite/DataAdr/WriteData       core store bus
//   done/pass                        verdict valid / verdict is PASS
//   fail_code/fail_addr/fail_data    failure cause and offending store
//   match_cnt                        entries matched so far
// -----------------------------------------------------------------------------
module store_checker
   import chk_pkg::*;
#(
   parameter int  NUM_CHECKS = 4,
   parameter int  ADDR_W     = 32,
   parameter int  DATA_W     = 32,
   parameter int  TIMEOUT    = 200,
   parameter int  ORDERED    = 1,
   localparam int IDX_W      = $clog2(NUM_CHECKS),
   localparam int CNT_W      = $clog2(NUM_CHECKS + 1),
   localparam int TMR_W      = $clog2(TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [DATA_W-1:0] cfg_data,
   input  logic [CNT_W-1:0]  num_checks,
   input  logic [ADDR_W-1:0] ign_base,
   input  logic [ADDR_W-1:0] ign_mask,
   input  logic              start,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] DataAdr,
   input  logic [DATA_W-1:0] WriteData,
   output logic              done,
   output logic              pass,
   output fail_e             fail_code,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data,
   output logic [CNT_W-1:0]  match_cnt
);

   chk_state_e             state_r, state_s;
   logic [NUM_CHECKS-1:0]  seen_r, seen_s;
   logic [CNT_W-1:0]       match_cnt_r, match_cnt_s;
   logic [CNT_W-1:0]       nact_r, nact_s;
   logic [TMR_W-1:0]       cyc_r, cyc_s;
   logic                   done_r, done_s;
   logic                   pass_r, pass_s;
   fail_e                  fail_code_r, fail_code_s;
   logic [ADDR_W-1:0]      fail_addr_r, fail_addr_s;
   logic [DATA_W-1:0]      fail_data_r, fail_data_s;

   logic [NUM_CHECKS-1:0]  addr_hit_s;
   logic [NUM_CHECKS-1:0]  full_hit_s;
   logic [NUM_CHECKS-1:0]  elig_v_s;
   logic [NUM_CHECKS-1:0]  later_v_s;
   logic                   ok_hit_s;
   logic [IDX_W-1:0]       ok_idx_s;
   logic                   later_s;
   logic                   in_win_s;
   logic                   tmo_s;
   logic                   table_we_s;

   assign table_we_s = cfg_we && (state_r == S_IDLE);
   assign in_win_s   = ((DataAdr & ign_mask) == (ign_base & ign_mask));
   assign tmo_s      = (cyc_r == TMR_W'(TIMEOUT - 1));

   store_ref_table #(
      .NUM_CHECKS (NUM_CHECKS),
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W)
   ) u_table (
      .clk      (clk),
      .reset    (reset),
      .we       (table_we_s),
      .idx      (cfg_idx),
      .wr_addr  (cfg_addr),
      .wr_data  (cfg_data),
      .num_act  (nact_r),
      .st_addr  (DataAdr),
      .st_data  (WriteData),
      .addr_hit (addr_hit_s),
      .full_hit (full_hit_s)
   );

   // Which full hits are acceptable now, and which are ahead of the expected one.
   // Ordered: only entry match_cnt is eligible. Unordered: any unseen entry.
   always_comb begin
      elig_v_s  = '0;
      later_v_s = '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
         elig_v_s[i]  = full_hit_s[i] &&
                        ((ORDERED != 0) ? (CNT_W'(i) == match_cnt_r) : !seen_r[i]);
         later_v_s[i] = full_hit_s[i] && (ORDERED != 0) && (CNT_W'(i) > match_cnt_r);
      end
   end

   // Lowest-index eligible entry wins.
   always_comb begin
      ok_idx_s = '0;
      for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
         ok_idx_s = elig_v_s[i] ? IDX_W'(i) : ok_idx_s;
      end
      ok_hit_s = |elig_v_s;
      later_s  = |later_v_s;
   end

   // Next-state and verdict logic; a store in the last budget cycle is judged first.
   always_comb begin
      state_s     = state_r;
      seen_s      = seen_r;
      match_cnt_s = match_cnt_r;
      nact_s      = nact_r;
      cyc_s       = cyc_r;
      done_s      = done_r;
      pass_s      = pass_r;
      fail_code_s = fail_code_r;
      fail_addr_s = fail_addr_r;
      fail_data_s = fail_data_r;
      case (state_r)
         S_RUN: begin
            cyc_s = cyc_r + TMR_W'(1);
            if (MemWrite && ok_hit_s) begin
               seen_s[ok_idx_s] = 1'b1;
               match_cnt_s      = match_cnt_r + CNT_W'(1);
               if ((match_cnt_r + CNT_W'(1)) == nact_r) begin
                  state_s = S_PASS;
                  done_s  = 1'b1;
                  pass_s  = 1'b1;
               end else if (tmo_s) begin
                  state_s     = S_TIMEOUT;
                  done_s      = 1'b1;
                  fail_code_s = F_TIMEOUT;
               end else begin
                  state_s = S_RUN;
               end
            end else if (MemWrite && (|addr_hit_s)) begin
               state_s     = S_FAIL;
               done_s      = 1'b1;
               fail_addr_s = DataAdr;
               fail_data_s = WriteData;
               // No entry at this address carries this data -> wrong data.
               if (!(|full_hit_s)) begin
                  fail_code_s = F_DATA;
               end else if (later_s) begin
                  fail_code_s = F_ORDER;
               end else begin
                  fail_code_s = F_DUP;
               end
            end else if (MemWrite && !in_win_s) begin
               state_s     = S_FAIL;
               done_s      = 1'b1;
               fail_code_s = F_ADDR;
               fail_addr_s = DataAdr;
               fail_data_s = WriteData;
            end else if (tmo_s) begin
               state_s     = S_TIMEOUT;
               done_s      = 1'b1;
               fail_code_s = F_TIMEOUT;
            end else begin
               state_s = S_RUN;
            end
         end
         S_IDLE, S_PASS, S_FAIL, S_TIMEOUT: begin
            if (start) begin
               nact_s      = num_checks;
               seen_s      = '0;
               match_cnt_s = '0;
               cyc_s       = '0;
               done_s      = 1'b0;
               pass_s      = 1'b0;
               fail_code_s = F_NONE;
               fail_addr_s = '0;
               fail_data_s = '0;
               if (num_checks == '0) begin
                  state_s = S_PASS;
                  done_s  = 1'b1;
                  pass_s  = 1'b1;
               end else begin
                  state_s = S_RUN;
               end
            end else begin
               state_s = state_r;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= S_IDLE;
         seen_r      <= '0;
         match_cnt_r <= '0;
         nact_r      <= '0;
         cyc_r       <= '0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         fail_code_r <= F_NONE;
         fail_addr_r <= '0;
         fail_data_r <= '0;
      end else begin
         state_r     <= state_s;
         seen_r      <= seen_s;
         match_cnt_r <= match_cnt_s;
         nact_r      <= nact_s;
         cyc_r       <= cyc_s;
         done_r      <= done_s;
         pass_r      <= pass_s;
         fail_code_r <= fail_code_s;
         fail_addr_r <= fail_addr_s;
         fail_data_r <= fail_data_s;
      end
   end

   assign done      = done_r;
   assign pass      = pass_r;
   assign fail_code = fail_code_r;
   assign fail_addr = fail_addr_r;
   assign fail_data = fail_data_r;
   assign match_cnt = match_cnt_r;

endmodule

// File: tb/tb_store_checker.sv
// -----------------------------------------------------------------------------
// tb_store_checker
// Drives an ordered and an unordered checker (TIMEOUT=20) from the same inputs
// and compares every output of both after each clock edge with a behavioural
// model of the matching rules. Directed scenarios come first, then random
// tables and store streams.
// -----------------------------------------------------------------------------
module tb_store_checker;

   localparam int C_NONE = 0, C_DATA = 1, C_ADDR = 2, C_ORDER = 3, C_DUP = 4, C_TMO = 5;
   localparam int TMO    = 20;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_we;
   logic [1:0]  cfg_idx;
   logic [31:0] cfg_addr, cfg_data;
   logic [2:0]  num_checks;
   logic [31:0] ign_base, ign_mask;
   logic        start;
   logic        MemWrite;
   logic [31:0] DataAdr, WriteData;

   logic        done_o, pass_o, done_u, pass_u;
   logic [2:0]  code_o, code_u, mcnt_o, mcnt_u;
   logic [31:0] faddr_o, fdata_o, faddr_u, fdata_u;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   store_checker #(.NUM_CHECKS(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .ORDERED(1)) dut_o (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .num_checks(num_checks), .ign_base(ign_base), .ign_mask(ign_mask),
      .start(start), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
      .done(done_o), .pass(pass_o), .fail_code(code_o), .fail_addr(faddr_o),
      .fail_data(fdata_o), .match_cnt(mcnt_o));

   store_checker #(.NUM_CHECKS(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .ORDERED(0)) dut_u (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .num_checks(num_checks), .ign_base(ign_base), .ign_mask(ign_mask),
      .start(start), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
      .done(done_u), .pass(pass_u), .fail_code(code_u), .fail_addr(faddr_u),
      .fail_data(fdata_u), .match_cnt(mcnt_u));

   // ---------------- reference model (index 0: unordered, 1: ordered) ----------------
   logic [31:0] t_addr [4];
   logic [31:0] t_data [4];
   bit          m_idle;
   bit          m_run  [2];
   bit          m_done [2];
   bit          m_pass [2];
   int          m_code [2];
   logic [31:0] m_fa   [2];
   logic [31:0] m_fd   [2];
   int          m_cnt  [2];
   int          m_nact [2];
   int          m_cyc  [2];
   bit          m_seen [2][4];

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         t_addr[i] = 32'd0;
         t_data[i] = 32'd0;
      end
      m_idle = 1'b1;
      for (int k = 0; k < 2; k++) begin
         m_run[k] = 1'b0; m_done[k] = 1'b0; m_pass[k] = 1'b0; m_code[k] = C_NONE;
         m_fa[k] = 32'd0; m_fd[k] = 32'd0; m_cnt[k] = 0; m_nact[k] = 0; m_cyc[k] = 0;
         for (int i = 0; i < 4; i++) m_seen[k][i] = 1'b0;
      end
   endtask

   task automatic model_fail(input int k, input int code);
      m_run[k]  = 1'b0;
      m_done[k] = 1'b1;
      m_code[k] = code;
      m_fa[k]   = DataAdr;
      m_fd[k]   = WriteData;
   endtask

   // One clock edge of both checkers, from the inputs present at that edge.
   task automatic model_edge();
      bit was_idle;
      was_idle = m_idle;
      for (int k = 0; k < 2; k++) begin
         if (start && !m_run[k]) begin
            m_nact[k] = int'(num_checks);
            m_cnt[k] = 0; m_cyc[k] = 0;
            for (int i = 0; i < 4; i++) m_seen[k][i] = 1'b0;
            m_code[k] = C_NONE; m_fa[k] = 32'd0; m_fd[k] = 32'd0;
            m_done[k] = (m_nact[k] == 0);
            m_pass[k] = (m_nact[k] == 0);
            m_run[k]  = (m_nact[k] != 0);
            m_idle    = 1'b0;
         end else if (m_run[k]) begin
            bit verdict = 1'b0;
            if (MemWrite) begin
               int  e = -1;
               bit  ahit = 1'b0, anyfull = 1'b0, later = 1'b0;
               for (int i = 0; i < m_nact[k]; i++) begin
                  if (t_addr[i] == DataAdr) begin
                     ahit = 1'b1;
                     if (t_data[i] == WriteData) begin
                        anyfull = 1'b1;
                        if (k == 1 && i > m_cnt[k]) later = 1'b1;
                        if (e < 0 && ((k == 1) ? (i == m_cnt[k]) : !m_seen[k][i])) e = i;
                     end
                  end
               end
               if (e >= 0) begin
                  m_seen[k][e] = 1'b1;
                  m_cnt[k]++;
                  if (m_cnt[k] == m_nact[k]) begin
                     m_run[k] = 1'b0; m_done[k] = 1'b1; m_pass[k] = 1'b1; verdict = 1'b1;
                  end
               end else if (ahit) begin
                  model_fail(k, !anyfull ? C_DATA : (later ? C_ORDER : C_DUP));
                  verdict = 1'b1;
               end else if ((DataAdr & ign_mask) != (ign_base & ign_mask)) begin
                  model_fail(k, C_ADDR);
                  verdict = 1'b1;
               end
            end
            if (!verdict && m_cyc[k] == TMO - 1) begin
               m_run[k] = 1'b0; m_done[k] = 1'b1; m_code[k] = C_TMO;
            end
            m_cyc[k]++;
         end
      end
      if (cfg_we && was_idle) begin
         t_addr[cfg_idx] = cfg_addr;
         t_data[cfg_idx] = cfg_data;
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("ord.done", 32'(done_o), 32'(m_done[1]));
      chk("ord.pass", 32'(pass_o), 32'(m_pass[1]));
      chk("ord.code", 32'(code_o), 32'(m_code[1]));
      chk("ord.faddr", faddr_o, m_fa[1]);
      chk("ord.fdata", fdata_o, m_fd[1]);
      chk("ord.mcnt", 32'(mcnt_o), 32'(m_cnt[1]));
      chk("uno.done", 32'(done_u), 32'(m_done[0]));
      chk("uno.pass", 32'(pass_u), 32'(m_pass[0]));
      chk("uno.code", 32'(code_u), 32'(m_code[0]));
      chk("uno.faddr", faddr_u, m_fa[0]);
      chk("uno.fdata", fdata_u, m_fd[0]);
      chk("uno.mcnt", 32'(mcnt_u), 32'(m_cnt[0]));
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic cfg(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
      cyc();
      cfg_we = 1'b0;
   endtask

   task automatic go(input logic [2:0] n);
      num_checks = n; start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      MemWrite = 1'b1; DataAdr = a; WriteData = d;
      cyc();
      MemWrite = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      cfg_we = 1'b0; cfg_idx = 2'd0; cfg_addr = 32'd0; cfg_data = 32'd0;
      num_checks = 3'd0; ign_base = 32'd96; ign_mask = 32'hFFFF_FFFF;
      start = 1'b0; MemWrite = 1'b0; DataAdr = 32'd0; WriteData = 32'd0;
      do_reset();
      chk("reset.done", 32'(done_o), 32'd0);
      chk("reset.code", 32'(code_u), 32'd0);

      // 1: ignored store then the single expected store
      cfg(2'd0, 32'd100, 32'd25);
      go(3'd1);
      store(32'd96, 32'd7);
      chk("t1.pending", 32'(done_o), 32'd0);
      store(32'd100, 32'd25);
      chk("t1.pass", 32'(pass_o), 32'd1);
      chk("t1.mcnt", 32'(mcnt_u), 32'd1);

      // 2: store outside table and window
      go(3'd1);
      store(32'd104, 32'd3);
      chk("t2.code", 32'(code_o), 32'(C_ADDR));
      chk("t2.faddr", faddr_u, 32'd104);
      chk("t2.fdata", fdata_o, 32'd3);

      // 3: order and duplicate rules
      do_reset();
      cfg(2'd0, 32'd0, 32'd1);
      cfg(2'd1, 32'd4, 32'd2);
      go(3'd2);
      store(32'd4, 32'd2);
      chk("t3.order", 32'(code_o), 32'(C_ORDER));
      store(32'd0, 32'd1);
      chk("t3.uno_pass", 32'(pass_u), 32'd1);
      go(3'd2);
      store(32'd4, 32'd2);
      store(32'd4, 32'd2);
      chk("t3.dup", 32'(code_u), 32'(C_DUP));

      // 4: timeout, and a final match on the last budget cycle
      go(3'd2);
      idle(TMO - 1);
      chk("t4.not_yet", 32'(done_o), 32'd0);
      idle(1);
      chk("t4.tmo_o", 32'(code_o), 32'(C_TMO));
      chk("t4.tmo_u", 32'(code_u), 32'(C_TMO));
      go(3'd2);
      idle(TMO - 3);
      store(32'd0, 32'd1);
      idle(1);
      store(32'd4, 32'd2);
      chk("t4.edge_pass_o", 32'(pass_o), 32'd1);
      chk("t4.edge_code_u", 32'(code_u), 32'(C_NONE));

      // 5: empty table, then table write during RUN is ignored
      go(3'd0);
      chk("t5.empty_pass", 32'(pass_u), 32'd1);
      go(3'd1);
      cfg(2'd0, 32'd0, 32'd9);
      store(32'd0, 32'd1);
      chk("t5.table_kept", 32'(pass_o), 32'd1);

      // 6: asynchronous reset after one of two matches, then re-arm
      go(3'd2);
      store(32'd0, 32'd1);
      chk("t6.one", 32'(mcnt_o), 32'd1);
      do_reset();
      chk("t6.rst_mcnt", 32'(mcnt_o), 32'd0);
      chk("t6.rst_done", 32'(done_u), 32'd0);
      go(3'd2);
      store(32'd0, 32'd0);
      store(32'd0, 32'd0);
      chk("t6.rearm_pass", 32'(pass_o), 32'd1);

      // random tables and store streams
      for (int t = 0; t < 20; t++) begin
         do_reset();
         ign_base = 32'($urandom_range(0, 15)) * 32'd4;
         case ($urandom_range(0, 2))
            0: ign_mask = 32'hFFFF_FFFF;
            1: ign_mask = 32'hFFFF_FFF0;
            default: ign_mask = 32'd0;
         endcase
         for (int i = 0; i < 4; i++)
            cfg(2'(i), 32'($urandom_range(0, 7)) * 32'd4, 32'($urandom_range(0, 3)));
         go(3'($urandom_range(0, 4)));
         for (int c = 0; c < 24; c++) begin
            int r, j;
            r = int'($urandom_range(0, 3));
            j = int'($urandom_range(0, 3));
            if (r == 0 && m_cnt[1] < 4) j = m_cnt[1];
            MemWrite  = ($urandom_range(0, 3) != 0);
            DataAdr   = (r == 3) ? 32'($urandom_range(0, 15)) * 32'd4 : t_addr[j];
            WriteData = (r == 2) ? 32'($urandom_range(0, 3)) : t_data[j];
            cyc();
         end
         MemWrite = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
